aho_sequencer: RTL and testbench
================================

# aho_sequencer

Sequencing controller for the "aho" counting game. On START it steps a 3-digit BCD counter from 1 to MAX_NUM and presents one number at a time on a valid/ready output port. Each number carries an AHO flag that is set when the number is a multiple of 3 or contains the digit 3. The block sits between the seminar's counting datapath and a display or announcer sink, and owns pacing, back-pressure, abort and completion signalling.

## Interface
- MAX_NUM, 100: last number announced; legal range 1..999.
- GAP_CYCLES, 3: idle cycles inserted before each number is presented; legal range 0..255.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  begin a sequence; sampled only in IDLE.
- STOP  in  1  abort the running sequence.
- OUT_RDY  in  1  sink ready.
- OUT_VLD  out  1  NUM_BCD and AHO are valid.
- NUM_BCD  out  12  current number as BCD: [11:8] hundreds, [7:4] tens, [3:0] ones.
- AHO  out  1  number is a multiple of 3 or contains a 3 digit.
- BUSY  out  1  sequence in progress (GAP or PRESENT).
- DONE  out  1  one-cycle pulse after the MAX_NUM transfer completes.

## Operation
- State machine: IDLE, GAP, PRESENT, FINISH.
- **IDLE**
  - START=1 and STOP=0: load NUM_BCD=12'h001, residue=1, and gap count=GAP_CYCLES.
  - Go to GAP, or directly to PRESENT when GAP_CYCLES=0.
  - START is ignored in every other state.
- **GAP**
  - The gap counter decrements each cycle.
  - Move to PRESENT on the cycle the counter would reach 0, so GAP lasts exactly GAP_CYCLES cycles.
- **PRESENT**
  - OUT_VLD=1. NUM_BCD and AHO are held stable until the handshake.
  - Handshake is OUT_VLD & OUT_RDY.
  - On handshake with NUM_BCD==MAX_NUM (in BCD): go to FINISH.
  - On any other handshake: increment NUM_BCD, advance the residue, reload the gap counter, and go to GAP (or stay in PRESENT when GAP_CYCLES=0).
- **FINISH**
  - DONE=1 for exactly one cycle, then go to IDLE.
  - NUM_BCD keeps the final value until the next START.
- **STOP**
  - STOP in GAP or PRESENT: go to IDLE next cycle, clear NUM_BCD to 0, no DONE pulse.
  - If STOP coincides with a handshake, that transfer counts as delivered, but the sequence still aborts.
  - START and STOP together in IDLE: STOP wins and the block stays in IDLE.
- **BCD increment**
  - Each digit wraps 9→0 with a carry into the next digit, e.g. 099→100 and 109→110.
  - No arithmetic beyond 999 is ever required.
- **Residue**
  - 2-bit mod-3 counter, 1→2→0→1, updated in the same cycle as NUM_BCD.
  - No division is used.
- **AHO**
  - AHO = OUT_VLD & ((residue==0) | (any digit==4'd3)).
  - Derived from registers only; there is no combinational path from inputs.
  - AHO=0 whenever OUT_VLD=0.

## Timing
- **Reset:** state IDLE; OUT_VLD=0, NUM_BCD=0, AHO=0, BUSY=0, DONE=0, residue=0, gap counter=0.
- Reset asserted mid-sequence aborts immediately (asynchronously), with no DONE.
- **Start latency:** START sampled at edge t gives BUSY=1 from t+1 and first OUT_VLD at t+1+GAP_CYCLES.
- **Inter-number latency:** handshake at edge k gives the next OUT_VLD at k+1+GAP_CYCLES.
  - With GAP_CYCLES=0 and OUT_RDY held high, one number transfers per cycle.
- **Completion:** final handshake at edge k gives DONE=1 in cycle k+1, BUSY=0 from k+1, and IDLE at k+2.
  - A START may be accepted from k+2 onward.
- **Back-pressure:** OUT_RDY=0 holds PRESENT indefinitely, with outputs unchanged.
- **MAX_NUM=1:** single transfer of 001 with AHO=0, then DONE.

## Test plan
- MAX_NUM=15, GAP_CYCLES=0, OUT_RDY=1, START pulse:
  - Numbers 1..15 appear on 15 consecutive cycles.
  - AHO=1 exactly at 3, 6, 9, 12, 13, 15.
  - DONE pulses one cycle after 15.
- MAX_NUM=40, GAP_CYCLES=2:
  - AHO=1 for every number 30..39 and for 33.
  - AHO=0 for 31→? no: 31 has digit 3, so AHO=1; 40 gives AHO=0.
  - Exactly 2 idle cycles precede each OUT_VLD.
- MAX_NUM=105, GAP_CYCLES=0:
  - BCD carry 099→100 (12'h100, AHO=0).
  - 102 gives AHO=1; 103 gives AHO=1 (digit 3); 105 gives AHO=1 (mod 3).
- Back-pressure:
  - OUT_RDY low for 5 cycles at number 7: OUT_VLD stays 1 and NUM_BCD stays 12'h007 throughout.
  - 008 appears only after OUT_RDY rises.
- STOP while NUM_BCD=12'h012 in PRESENT, with OUT_RDY=1 in the same cycle:
  - IDLE next cycle, NUM_BCD=0, no DONE.
  - A following START restarts from 001.
- RST asserted asynchronously mid-GAP: all outputs are 0 immediately; START while BUSY=1 and START+STOP in IDLE are both ignored.

Source files
------------

// File: rtl/aho_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : aho_sequencer
//  Purpose  : Paces a 3-digit BCD count 1..MAX_NUM onto a valid/ready port,
//             tagging each number with the AHO flag (multiple of 3 or any
//             digit equal to 3). Handles gap insertion, back-pressure, abort
//             and a one-cycle completion pulse.
//  Revision : 1.0  initial release
// ============================================================================
module aho_sequencer #(
  parameter int MAX_NUM    = 100,
  parameter int GAP_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic        OUT_RDY,
  output logic        OUT_VLD,
  output logic [11:0] NUM_BCD,
  output logic        AHO,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GAP     = 2'd1,
    S_PRESENT = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  // Final number in BCD so the end test is a plain 12-bit compare.
  localparam logic [11:0] c_max_bcd  = {4'(MAX_NUM / 100), 4'((MAX_NUM / 10) % 10), 4'(MAX_NUM % 10)};
  localparam logic [7:0]  c_gap_load = 8'(GAP_CYCLES);
  localparam bit          c_no_gap   = (GAP_CYCLES == 0);

  state_t      state_q, state_d;
  logic [11:0] num_q,   num_d;
  logic [1:0]  res_q,   res_d;
  logic [7:0]  gap_q,   gap_d;

  // Ripple-carry BCD increment; each digit wraps 9 -> 0 and carries upward.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end
    end
    return r;
  endfunction

  // Next-state logic: sequencing, gap countdown, number/residue advance, abort.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    res_d   = res_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          num_d   = 12'h001;
          res_d   = 2'd1;
          gap_d   = c_gap_load;
          state_d = c_no_gap ? S_PRESENT : S_GAP;
        end
      end
      S_GAP: begin
        if (STOP) begin
          state_d = S_IDLE;
          num_d   = 12'h000;
          res_d   = 2'd0;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q - 8'd1;
          // Leave on the cycle the counter would hit zero.
          if (gap_q <= 8'd1) begin
            gap_d   = 8'd0;
            state_d = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        if (STOP) begin
          // A coincident handshake is still delivered to the sink; we just abort.
          state_d = S_IDLE;
          num_d   = 12'h000;
          res_d   = 2'd0;
          gap_d   = 8'd0;
        end else if (OUT_RDY) begin
          if (num_q == c_max_bcd) begin
            state_d = S_FINISH;
          end else begin
            num_d   = bcd_inc(num_q);
            res_d   = (res_q == 2'd2) ? 2'd0 : res_q + 2'd1;
            gap_d   = c_gap_load;
            state_d = c_no_gap ? S_PRESENT : S_GAP;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      num_q   <= 12'h000;
      res_q   <= 2'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      res_q   <= res_d;
      gap_q   <= gap_d;
    end
  end

  // Outputs decode from registers only; AHO is gated by OUT_VLD.
  always_comb begin
    OUT_VLD = (state_q == S_PRESENT);
    BUSY    = (state_q == S_GAP) || (state_q == S_PRESENT);
    DONE    = (state_q == S_FINISH);
    NUM_BCD = num_q;
    AHO     = OUT_VLD && ((res_q == 2'd0) || (num_q[3:0] == 4'd3) ||
                          (num_q[7:4] == 4'd3) || (num_q[11:8] == 4'd3));
  end

endmodule
`default_nettype wire

// File: tb/tb_aho_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aho_sequencer
//  Purpose  : Self-checking bench for aho_sequencer. Four instances with
//             different MAX_NUM/GAP_CYCLES run side by side against a
//             timeline reference model; directed tables and sequences cover
//             the corner cases, then randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aho_sequencer;

  localparam int NI = 4;
  localparam int MAXS [NI] = '{40, 105, 15, 1};
  localparam int GAPS [NI] = '{2, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start [NI];
  logic        stop  [NI];
  logic        rdy   [NI];
  logic        vld   [NI];
  logic [11:0] num   [NI];
  logic        aho   [NI];
  logic        busy  [NI];
  logic        done  [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a sequence is described by when things happen, in cycles.
  bit m_busy      [NI];
  int m_cur       [NI];
  int m_vld_from  [NI];
  int m_done_cyc  [NI];
  int m_idle_from [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aho_sequencer #(.MAX_NUM(MAXS[g]), .GAP_CYCLES(GAPS[g])) u_dut (
      .CLK     (clk),
      .RST     (rst),
      .START   (start[g]),
      .STOP    (stop[g]),
      .OUT_RDY (rdy[g]),
      .OUT_VLD (vld[g]),
      .NUM_BCD (num[g]),
      .AHO     (aho[g]),
      .BUSY    (busy[g]),
      .DONE    (done[g])
    );
  end

  function automatic logic [11:0] to_bcd(input int n);
    return 12'((n / 100) * 256 + ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  function automatic bit aho_rule(input int n);
    return (n % 3 == 0) || (n % 10 == 3) || ((n / 10) % 10 == 3) || (n / 100 == 3);
  endfunction

  task automatic check_b(input int inst, input string name, input bit act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s actual=%0d required=%0d (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  task automatic check_n(input int inst, input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s actual=%0h required=%0h (t=%0t)", inst, name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_busy[i]      = 1'b0;
      m_cur[i]       = 0;
      m_vld_from[i]  = 0;
      m_done_cyc[i]  = -1;
      m_idle_from[i] = cyc;
    end
  endtask

  // Predict the effect of the upcoming edge (cyc+1) given the current inputs.
  task automatic model_edge(input int i);
    int e;
    bit v;
    e = cyc + 1;
    v = m_busy[i] && (cyc >= m_vld_from[i]);
    if (m_busy[i]) begin
      if (stop[i]) begin
        m_busy[i]      = 1'b0;
        m_cur[i]       = 0;
        m_idle_from[i] = e;
      end else if (v && rdy[i]) begin
        if (m_cur[i] == MAXS[i]) begin
          m_busy[i]      = 1'b0;
          m_done_cyc[i]  = e;
          m_idle_from[i] = e + 1;
        end else begin
          m_cur[i]      = m_cur[i] + 1;
          m_vld_from[i] = e + GAPS[i];
        end
      end
    end else if (cyc >= m_idle_from[i] && start[i] && !stop[i]) begin
      m_busy[i]     = 1'b1;
      m_cur[i]      = 1;
      m_vld_from[i] = e + GAPS[i];
    end
  endtask

  task automatic check_inst(input int i);
    bit ev;
    ev = m_busy[i] && (cyc >= m_vld_from[i]);
    check_b(i, "vld",  vld[i],  ev);
    check_b(i, "busy", busy[i], m_busy[i]);
    check_b(i, "done", done[i], cyc == m_done_cyc[i]);
    check_n(i, "num",  num[i],  to_bcd(m_cur[i]));
    check_b(i, "aho",  aho[i],  ev && aho_rule(m_cur[i]));
  endtask

  task automatic step();
    for (int i = 0; i < NI; i++) model_edge(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  typedef struct packed {
    bit          start;
    bit          stop;
    bit          rdy;
    bit          vld;
    logic [11:0] num;
    bit          aho;
    bit          busy;
    bit          done;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int gap;
    int seen;

    // Directed vectors for instance 2 (MAX_NUM=15, GAP_CYCLES=0).
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h002, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h004, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h005, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h006, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h007, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h008, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h009, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h011, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h012, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h013, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h014, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h015, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h015, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h015, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 12'h002, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      stop[i]  = 1'b0;
      rdy[i]   = 1'b1;
    end

    // Reset state.
    @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) check_inst(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Table-driven run of instance 2.
    for (int r = 0; r < 21; r++) begin
      start[2] = tbl[r].start;
      stop[2]  = tbl[r].stop;
      rdy[2]   = tbl[r].rdy;
      step();
      check_b(2, "tbl_vld",  vld[2],  tbl[r].vld);
      check_n(2, "tbl_num",  num[2],  tbl[r].num);
      check_b(2, "tbl_aho",  aho[2],  tbl[r].aho);
      check_b(2, "tbl_busy", busy[2], tbl[r].busy);
      check_b(2, "tbl_done", done[2], tbl[r].done);
    end
    start[2] = 1'b0;
    stop[2]  = 1'b1;
    step();
    stop[2]  = 1'b0;

    // Instance 0 (MAX_NUM=40, GAP_CYCLES=2): gap length and back-pressure.
    start[0] = 1'b1;
    rdy[0]   = 1'b1;
    step();
    start[0] = 1'b0;
    gap = 0;
    while (!vld[0] && gap < 10) begin
      gap++;
      step();
    end
    check_n(0, "gap_len", 12'(gap), 12'd2);
    check_n(0, "first_num", num[0], 12'h001);

    for (int k = 0; k < 100 && !(vld[0] && num[0] == 12'h007); k++) step();
    check_b(0, "reach_007", vld[0] && num[0] == 12'h007, 1'b1);
    rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_b(0, "bp_vld", vld[0], 1'b1);
      check_n(0, "bp_num", num[0], 12'h007);
    end
    rdy[0] = 1'b1;
    step();
    check_b(0, "post_bp_gap", vld[0], 1'b0);
    step();
    step();
    check_b(0, "next_vld", vld[0], 1'b1);
    check_n(0, "next_num", num[0], 12'h008);

    // Abort with a coincident handshake at 12.
    for (int k = 0; k < 100 && !(vld[0] && num[0] == 12'h012); k++) step();
    check_b(0, "reach_012", vld[0] && num[0] == 12'h012, 1'b1);
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    check_b(0, "stop_busy", busy[0], 1'b0);
    check_n(0, "stop_num", num[0], 12'h000);
    for (int k = 0; k < 3; k++) begin
      step();
      check_b(0, "stop_nodone", done[0], 1'b0);
    end

    // Restart after abort begins at 001 with a fresh gap.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    gap = 0;
    while (!vld[0] && gap < 10) begin
      gap++;
      step();
    end
    check_n(0, "regap_len", 12'(gap), 12'd2);
    check_n(0, "restart_num", num[0], 12'h001);

    // START while busy is ignored; then async reset lands mid-GAP.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check_n(0, "busy_start_ign", num[0], 12'h002);
    check_b(0, "in_gap", busy[0] && !vld[0], 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) check_inst(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Instances 1 (MAX_NUM=105) and 3 (MAX_NUM=1), GAP_CYCLES=0.
    start[1] = 1'b1;
    start[3] = 1'b1;
    rdy[1]   = 1'b1;
    rdy[3]   = 1'b1;
    step();
    start[1] = 1'b0;
    start[3] = 1'b0;
    check_n(3, "one_num", num[3], 12'h001);
    check_b(3, "one_aho", aho[3], 1'b0);
    check_b(3, "one_vld", vld[3], 1'b1);
    step();
    check_b(3, "one_done", done[3], 1'b1);
    seen = 0;
    for (int k = 0; k < 120; k++) begin
      if (vld[1]) begin
        case (num[1])
          12'h100: begin check_b(1, "aho_100", aho[1], 1'b0); seen++; end
          12'h102: begin check_b(1, "aho_102", aho[1], 1'b1); seen++; end
          12'h103: begin check_b(1, "aho_103", aho[1], 1'b1); seen++; end
          12'h105: begin check_b(1, "aho_105", aho[1], 1'b1); seen++; end
          default: ;
        endcase
      end
      step();
    end
    check_n(1, "seen_marks", 12'(seen), 12'd4);
    check_b(1, "run105_over", busy[1], 1'b0);
    check_n(1, "final_num", num[1], 12'h105);

    // Randomized traffic on all instances against the model.
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < NI; i++) begin
        start[i] = ($urandom_range(9) == 0);
        stop[i]  = ($urandom_range(99) == 0);
        rdy[i]   = ($urandom_range(3) != 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
